// File: rtl/run_controller.sv
// Run controller: holds a processor in reset, runs it for a bounded budget, and reports halt/timeout.
// Optional PC-stable halt detection is compiled in with RUN_HALT_DETECT_EN.
module run_controller #(
    parameter int CNT_WIDTH    = 32,
    parameter int RESET_CYCLES = 4,
    parameter int MAX_CYCLES   = 200,
    parameter int PC_WIDTH     = 32,
    parameter int HALT_STABLE  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 halt_req,
    input  logic [PC_WIDTH-1:0]  pc,
    output logic                 proc_reset,
    output logic                 running,
    output logic                 done,
    output logic                 timed_out,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [1:0]           dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 timed_out_q, timed_out_d;
    logic                 halted_q, halted_d;
    logic                 pc_halt;

`ifdef RUN_HALT_DETECT_EN
    localparam int STABLE_W = (HALT_STABLE > 2) ? $clog2(HALT_STABLE) : 1;
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(HALT_STABLE - 2);

    logic [PC_WIDTH-1:0] last_pc_q, last_pc_d;
    logic                pc_valid_q, pc_valid_d;
    logic [STABLE_W-1:0] stable_q, stable_d;

    // stable_q counts matching consecutive pairs, so HALT_STABLE identical cycles
    // are reached when HALT_STABLE-2 pairs were already seen and this one matches too.
    always_comb begin
        last_pc_d  = last_pc_q;
        pc_valid_d = pc_valid_q;
        stable_d   = stable_q;
        pc_halt    = 1'b0;
        if (state_q == ST_HOLD) begin
            last_pc_d  = '0;
            pc_valid_d = 1'b0;
            stable_d   = '0;
        end else if (state_q == ST_RUN) begin
            last_pc_d  = pc;
            pc_valid_d = 1'b1;
            if (pc_valid_q && (pc == last_pc_q)) begin
                pc_halt  = (stable_q == STABLE_LAST);
                stable_d = stable_q + STABLE_W'(1);
            end else begin
                stable_d = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_pc_q  <= '0;
            pc_valid_q <= 1'b0;
            stable_q   <= '0;
        end else begin
            last_pc_q  <= last_pc_d;
            pc_valid_q <= pc_valid_d;
            stable_q   <= stable_d;
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
    assign pc_halt   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        timed_out_d = timed_out_q;
        halted_d    = halted_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_HOLD;
                    hold_d      = '0;
                    cnt_d       = '0;
                    timed_out_d = 1'b0;
                    halted_d    = 1'b0;
                end
            end
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                // Halt wins over timeout when both land on the same cycle.
                if (halt_req || pc_halt) begin
                    state_d  = ST_DONE;
                    halted_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_DONE;
                    timed_out_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            timed_out_q <= timed_out_d;
            halted_q    <= halted_d;
        end
    end

    assign proc_reset  = (state_q != ST_RUN);
    assign running     = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign timed_out   = timed_out_q;
    assign halted      = halted_q;
    assign cycle_count = cnt_q;
    assign dbg_state   = state_q;

endmodule
